// File: rtl/pe_idx_loader_pkg.sv
// -----------------------------------------------------------------------------
// pe_idx_loader_pkg
//   Global parameters for the PE index path, shared by the loader and the AGU.
//   Contents:
//     IDX_W      width of one index field (a packed index word is 2*IDX_W)
//     bw()       address width needed to index a buffer of a given depth
//     MODE_*     AGU mode encodings
//     agu_cmd_t  bundle of the AGU instruction fields
// -----------------------------------------------------------------------------
package pe_idx_loader_pkg;

   localparam int IDX_W = 16;

   // Width of an address covering n entries; never narrower than 1 bit.
   function automatic int bw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam logic [1:0] MODE_CONV_FWD = 2'b00;
   localparam logic [1:0] MODE_FC_FWD   = 2'b01;
   localparam logic [1:0] MODE_CONV_BWD = 2'b10;
   localparam logic [1:0] MODE_FC_BWD   = 2'b11;

   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] idx_cnt;
      logic [7:0] trip_cnt;
      logic       is_new;
      logic [3:0] pad_code;   // {R,L,D,U}
      logic       cut_y;
   } agu_cmd_t;

endpackage

// File: rtl/pe_idx_loader_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Free-running event counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk    clock
//     rst    synchronous active-high clear
//     inc    count this cycle
//     count  current value (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pe_idx_loader.sv
// -----------------------------------------------------------------------------
// pe_idx_loader
//   Writer/issuer side of the PE AGU index interface. Takes a layer command and
//   a stream of packed index words, writes the words into the AGU's ping-pong
//   index buffer, then (once the AGU is idle) flips the buffer and pulses
//   start with the latched instruction fields. Loading the next bank overlaps
//   the AGU's run on the current one.
//
//   Optional build macro PE_IDX_LOADER_STALL_CNT_EN adds two saturating
//   32-bit counters: stall_cnt (cycles waiting on a busy AGU) and
//   load_stall_cnt (load cycles with no stream word offered).
//
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     cmd_valid/cmd_ready           command handshake
//     cmd_mode..cmd_cut_y           command fields (cmd_idx_cnt = words to load)
//     s_data/s_valid/s_ready        index word stream
//     idx_wr_data/addr/en           index buffer write port
//     switch_idx_buf                one-cycle bank flip pulse
//     start                         one-cycle AGU start pulse
//     mode..cut_y                   AGU instruction fields, held between starts
//     agu_done                      AGU idle level
//     busy                          loader not idle
//     stall_cnt, load_stall_cnt     (macro only) stall counters
// -----------------------------------------------------------------------------
module pe_idx_loader #(
   parameter int IDX_W      = pe_idx_loader_pkg::IDX_W,
   parameter int IDX_DEPTH  = 256,
   parameter int IDX_ADDR_W = pe_idx_loader_pkg::bw(IDX_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_mode,
   input  logic [7:0]            cmd_idx_cnt,
   input  logic [7:0]            cmd_trip_cnt,
   input  logic                  cmd_is_new,
   input  logic [3:0]            cmd_pad_code,
   input  logic                  cmd_cut_y,
   input  logic [2*IDX_W-1:0]    s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [2*IDX_W-1:0]    idx_wr_data,
   output logic [IDX_ADDR_W-1:0] idx_wr_addr,
   output logic                  idx_wr_en,
   output logic                  switch_idx_buf,
   output logic                  start,
   output logic [1:0]            mode,
   output logic [7:0]            idx_cnt,
   output logic [7:0]            trip_cnt,
   output logic                  is_new,
   output logic [3:0]            pad_code,
   output logic                  cut_y,
   input  logic                  agu_done,
   output logic                  busy
`ifdef PE_IDX_LOADER_STALL_CNT_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           load_stall_cnt
`endif
);

   import pe_idx_loader_pkg::*;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_WAIT_AGU = 3'd2;
   localparam logic [2:0] S_SWITCH   = 3'd3;
   localparam logic [2:0] S_START    = 3'd4;
   localparam logic [2:0] S_GUARD    = 3'd5;

   logic [2:0] state;
   logic [2:0] state_nxt;
   agu_cmd_t   cmd_q;
   logic [8:0] wcnt;        // one bit wider than idx_cnt so wcnt==cnt is reachable
   logic       cmd_hs;
   logic       s_hs;

   // cmd_ready / s_ready are only ever high in IDLE / LOAD respectively.
   assign cmd_hs = cmd_valid & cmd_ready;
   assign s_hs   = s_valid & s_ready;

   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned, which is what keeps a latch from being inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (cmd_hs) state_nxt = (cmd_idx_cnt != 8'd0) ? S_LOAD : S_WAIT_AGU;
         S_LOAD:     if (s_hs && ((wcnt + 9'd1) == {1'b0, cmd_q.idx_cnt})) state_nxt = S_WAIT_AGU;
         S_WAIT_AGU: if (agu_done) state_nxt = S_SWITCH;
         S_SWITCH:   state_nxt = S_START;
         S_START:    state_nxt = S_GUARD;
         // AGU drops done one cycle after start, so done is not trusted here.
         S_GUARD:    state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // All handshake and pulse outputs are registered from the next state, so
   // each is high exactly while the FSM sits in the matching state.
   // NOTE: state is updated with non-blocking assignments so every flop in this
   // block samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         cmd_q          <= '0;
         wcnt           <= '0;
         cmd_ready      <= 1'b0;
         s_ready        <= 1'b0;
         busy           <= 1'b0;
         switch_idx_buf <= 1'b0;
         start          <= 1'b0;
         idx_wr_en      <= 1'b0;
         idx_wr_addr    <= '0;
         idx_wr_data    <= '0;
         mode           <= '0;
         idx_cnt        <= '0;
         trip_cnt       <= '0;
         is_new         <= 1'b0;
         pad_code       <= '0;
         cut_y          <= 1'b0;
      end else begin
         state          <= state_nxt;
         cmd_ready      <= (state_nxt == S_IDLE);
         s_ready        <= (state_nxt == S_LOAD);
         busy           <= (state_nxt != S_IDLE);
         switch_idx_buf <= (state_nxt == S_SWITCH);
         start          <= (state_nxt == S_START);
         idx_wr_en      <= s_hs;

         if (cmd_hs) begin
            cmd_q <= '{mode: cmd_mode, idx_cnt: cmd_idx_cnt, trip_cnt: cmd_trip_cnt,
                       is_new: cmd_is_new, pad_code: cmd_pad_code, cut_y: cmd_cut_y};
            wcnt  <= '0;
         end

         if (s_hs) begin
            idx_wr_addr <= wcnt[IDX_ADDR_W-1:0];
            idx_wr_data <= s_data;
            wcnt        <= wcnt + 9'd1;
         end

         // Instruction fields change only together with the start pulse.
         if (state_nxt == S_START) begin
            mode     <= cmd_q.mode;
            idx_cnt  <= cmd_q.idx_cnt;
            trip_cnt <= cmd_q.trip_cnt;
            is_new   <= cmd_q.is_new;
            pad_code <= cmd_q.pad_code;
            cut_y    <= cmd_q.cut_y;
         end
      end
   end

`ifdef PE_IDX_LOADER_STALL_CNT_EN
   logic stall_inc;
   logic load_stall_inc;

   assign stall_inc      = (state == S_WAIT_AGU) && !agu_done;
   assign load_stall_inc = (state == S_LOAD) && !s_valid;

   sat_counter #(.W(32)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(32)) u_load_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (load_stall_inc),
      .count (load_stall_cnt)
   );
`endif

endmodule

// File: tb/tb_pe_idx_loader.sv
// -----------------------------------------------------------------------------
// tb_pe_idx_loader
//   Self-checking bench for pe_idx_loader. A negedge monitor logs every buffer
//   write, switch pulse and start pulse with its cycle number; each test builds
//   the expected write list from the words it offered and the commanded count,
//   and derives pulse timing from the AGU done level it drives.
//   Define PE_IDX_LOADER_STALL_CNT_EN to also exercise the stall counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pe_idx_loader;
   import pe_idx_loader_pkg::*;

   localparam int W = 2 * IDX_W;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_mode;
   logic [7:0]    cmd_idx_cnt;
   logic [7:0]    cmd_trip_cnt;
   logic          cmd_is_new;
   logic [3:0]    cmd_pad_code;
   logic          cmd_cut_y;
   logic [W-1:0]  s_data;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  idx_wr_data;
   logic [7:0]    idx_wr_addr;
   logic          idx_wr_en;
   logic          switch_idx_buf;
   logic          start;
   logic [1:0]    mode;
   logic [7:0]    idx_cnt;
   logic [7:0]    trip_cnt;
   logic          is_new;
   logic [3:0]    pad_code;
   logic          cut_y;
   logic          agu_done = 1'b1;
   logic          busy;
`ifdef PE_IDX_LOADER_STALL_CNT_EN
   logic [31:0]   stall_cnt;
   logic [31:0]   load_stall_cnt;
`endif

   pe_idx_loader dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_mode       (cmd_mode),
      .cmd_idx_cnt    (cmd_idx_cnt),
      .cmd_trip_cnt   (cmd_trip_cnt),
      .cmd_is_new     (cmd_is_new),
      .cmd_pad_code   (cmd_pad_code),
      .cmd_cut_y      (cmd_cut_y),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .idx_wr_data    (idx_wr_data),
      .idx_wr_addr    (idx_wr_addr),
      .idx_wr_en      (idx_wr_en),
      .switch_idx_buf (switch_idx_buf),
      .start          (start),
      .mode           (mode),
      .idx_cnt        (idx_cnt),
      .trip_cnt       (trip_cnt),
      .is_new         (is_new),
      .pad_code       (pad_code),
      .cut_y          (cut_y),
      .agu_done       (agu_done),
      .busy           (busy)
`ifdef PE_IDX_LOADER_STALL_CNT_EN
      ,
      .stall_cnt      (stall_cnt),
      .load_stall_cnt (load_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- AGU model: done drops the cycle after start ------------
   bit agu_auto  = 1'b0;
   bit agu_force = 1'b1;
   int agu_run   = 20;
   int agu_left  = 0;

   always @(posedge clk) begin
      #1;
      if (agu_auto) begin
         if (agu_left > 0) begin
            agu_done = 1'b0;
            agu_left--;
         end else begin
            agu_done = 1'b1;
         end
      end else begin
         agu_done = agu_force;
      end
   end

   // ---------------- Monitor ------------------------------------------------
   int        wr_addr_q[$];
   logic [W-1:0] wr_data_q[$];
   int        wr_cyc_q[$];
   int        sw_cyc_q[$];
   int        st_cyc_q[$];
   agu_cmd_t  st_f_q[$];
   int        sready_cyc;
   int        bubble_cyc;
   int        field_glitch = 0;
   int        done_rise_cyc = -1;
   agu_cmd_t  cur_f;
   agu_cmd_t  prev_f;
   logic      prev_rst  = 1'b1;
   logic      prev_done = 1'b0;

   always_comb cur_f = {mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y};

   always @(negedge clk) begin
      if (idx_wr_en) begin
         wr_addr_q.push_back(int'(idx_wr_addr));
         wr_data_q.push_back(idx_wr_data);
         wr_cyc_q.push_back(cyc);
      end
      if (switch_idx_buf) sw_cyc_q.push_back(cyc);
      if (start) begin
         st_cyc_q.push_back(cyc);
         st_f_q.push_back(cur_f);
         if (agu_auto) agu_left = agu_run;
      end
      if (s_ready) sready_cyc++;
      if (s_ready && !s_valid) bubble_cyc++;
      if (!start && !prev_rst && (cur_f != prev_f)) field_glitch++;
      if (agu_done && !prev_done) done_rise_cyc = cyc;
      prev_f    = cur_f;
      prev_rst  = rst;
      prev_done = agu_done;
   end

   // ---------------- Stimulus helpers ---------------------------------------
   logic [W-1:0] offer_q[$];

   task automatic clear_logs();
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      sw_cyc_q.delete();  st_cyc_q.delete();  st_f_q.delete();
      sready_cyc = 0;
      bubble_cyc = 0;
   endtask

   function automatic agu_cmd_t rand_cmd(input logic [7:0] cnt);
      agu_cmd_t   c;
      logic [1:0] modes [4];
      modes      = '{MODE_CONV_FWD, MODE_FC_FWD, MODE_CONV_BWD, MODE_FC_BWD};
      c.mode     = modes[$urandom_range(0, 3)];
      c.idx_cnt  = cnt;
      c.trip_cnt = 8'($urandom);
      c.is_new   = 1'($urandom);
      c.pad_code = 4'($urandom);
      c.cut_y    = 1'($urandom);
      return c;
   endfunction

   task automatic issue_cmd(input agu_cmd_t c, output int hs_cyc);
      @(posedge clk); #1;
      cmd_valid    = 1'b1;
      cmd_mode     = c.mode;
      cmd_idx_cnt  = c.idx_cnt;
      cmd_trip_cnt = c.trip_cnt;
      cmd_is_new   = c.is_new;
      cmd_pad_code = c.pad_code;
      cmd_cut_y    = c.cut_y;
      hs_cyc       = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            hs_cyc = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n_checks++;
      if (hs_cyc < 0) $display("FAIL cmd_handshake: cmd_ready never seen in 400 cycles");
      else n_pass++;
   endtask

   // Offers offer_q in order; a word counts as taken when valid&ready is seen
   // just before the rising edge.
   task automatic send_words(input bit bubbles, input int budget, output int acc);
      int idx = 0;
      bit ph  = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (idx >= offer_q.size()) break;
         s_valid = bubbles ? ph : 1'b1;
         s_data  = offer_q[idx];
         ph      = ~ph;
         @(negedge clk);
         if (s_valid && s_ready) idx++;
      end
      s_valid = 1'b0;
      acc     = idx;
   endtask

   task automatic wait_start(input int n, input int budget);
      int k = 0;
      while ((st_cyc_q.size() < n) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (st_cyc_q.size() < n)
         $display("FAIL start_timeout: saw %0d start pulses, expected %0d", st_cyc_q.size(), n);
      else n_pass++;
   endtask

   // ---------------- Tests --------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_mode = '0; cmd_idx_cnt = '0; cmd_trip_cnt = '0;
      cmd_is_new = 1'b0; cmd_pad_code = '0; cmd_cut_y = 1'b0;
      s_valid = 1'b0; s_data = '0;
      agu_force = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({cmd_ready, s_ready, idx_wr_en, switch_idx_buf, start, busy} !== 6'b0)
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {cmd_ready, s_ready, idx_wr_en, switch_idx_buf, start, busy});
      else n_pass++;
      n_checks++;
      if ({idx_wr_addr, idx_wr_data, cur_f} !== '0)
         $display("FAIL reset_data: addr %h data %h fields %h expected all zero",
                  idx_wr_addr, idx_wr_data, cur_f);
      else n_pass++;
`ifdef PE_IDX_LOADER_STALL_CNT_EN
      n_checks++;
      if ({stall_cnt, load_stall_cnt} !== 64'd0)
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, load_stall_cnt);
      else n_pass++;
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({cmd_ready, busy} !== 2'b10)
         $display("FAIL reset_release: cmd_ready/busy got %b expected 10", {cmd_ready, busy});
      else n_pass++;
   endtask

   task automatic test_basic_load();
      agu_cmd_t c;
      int hs, acc;
      clear_logs();
      agu_force = 1'b1;
      c = rand_cmd(8'd4);
      offer_q = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};
      issue_cmd(c, hs);
      send_words(1'b0, 50, acc);
      wait_start(1, 50);
      repeat (3) @(negedge clk);
      n_checks++;
      if (wr_addr_q.size() != 4 || acc != 4)
         $display("FAIL basic_count: writes %0d accepted %0d expected 4", wr_addr_q.size(), acc);
      else n_pass++;
      for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
         n_checks++;
         if (wr_addr_q[i] != i || wr_data_q[i] !== offer_q[i])
            $display("FAIL basic_write%0d: addr %0d data %h expected addr %0d data %h",
                     i, wr_addr_q[i], wr_data_q[i], i, offer_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (wr_cyc_q.size() == 0 || wr_cyc_q[0] - hs < 2)
         $display("FAIL basic_first_latency: cmd at %0d first write at %0d expected >=2 later",
                  hs, (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1);
      else n_pass++;
      n_checks++;
      if (sw_cyc_q.size() != 1 || wr_cyc_q.size() != 4 || sw_cyc_q[0] != wr_cyc_q[3] + 1)
         $display("FAIL basic_switch: %0d switches, first at %0d, expected 1 at last write+1",
                  sw_cyc_q.size(), (sw_cyc_q.size() > 0) ? sw_cyc_q[0] : -1);
      else n_pass++;
      n_checks++;
      if (st_cyc_q.size() != 1 || sw_cyc_q.size() < 1 || st_cyc_q[0] != sw_cyc_q[0] + 1)
         $display("FAIL basic_start: %0d starts, first at %0d, expected 1 at switch+1",
                  st_cyc_q.size(), (st_cyc_q.size() > 0) ? st_cyc_q[0] : -1);
      else n_pass++;
      n_checks++;
      if (st_f_q.size() < 1 || st_f_q[0] !== c || cur_f !== c)
         $display("FAIL basic_fields: at start %h now %h expected %h",
                  (st_f_q.size() > 0) ? st_f_q[0] : '0, cur_f, c);
      else n_pass++;
   endtask

   task automatic test_agu_wait();
      agu_cmd_t c;
      int hs, acc;
      logic [31:0] stall0;
      clear_logs();
      agu_force = 1'b0;
`ifdef PE_IDX_LOADER_STALL_CNT_EN
      stall0 = stall_cnt;
`else
      stall0 = '0;
`endif
      c = rand_cmd(8'd3);
      offer_q.delete();
      repeat (3) offer_q.push_back(W'($urandom));
      issue_cmd(c, hs);
      send_words(1'b0, 50, acc);
      repeat (50) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (sw_cyc_q.size() != 0 || st_cyc_q.size() != 0)
         $display("FAIL wait_early_pulse: %0d switches %0d starts while AGU busy, expected 0/0",
                  sw_cyc_q.size(), st_cyc_q.size());
      else n_pass++;
      agu_force = 1'b1;
      wait_start(1, 20);
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_addr_q.size() != 3)
         $display("FAIL wait_count: writes %0d expected 3", wr_addr_q.size());
      else n_pass++;
      for (int i = 0; i < wr_addr_q.size() && i < 3; i++) begin
         n_checks++;
         if (wr_addr_q[i] != i || wr_data_q[i] !== offer_q[i])
            $display("FAIL wait_write%0d: addr %0d data %h expected addr %0d data %h",
                     i, wr_addr_q[i], wr_data_q[i], i, offer_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (sw_cyc_q.size() != 1 || st_cyc_q.size() != 1 ||
          sw_cyc_q[0] != done_rise_cyc + 1 || st_cyc_q[0] != sw_cyc_q[0] + 1)
         $display("FAIL wait_release: switch at %0d start at %0d, done rose at %0d",
                  (sw_cyc_q.size() > 0) ? sw_cyc_q[0] : -1,
                  (st_cyc_q.size() > 0) ? st_cyc_q[0] : -1, done_rise_cyc);
      else n_pass++;
`ifdef PE_IDX_LOADER_STALL_CNT_EN
      n_checks++;
      if (wr_cyc_q.size() != 3 || stall_cnt - stall0 != 32'(done_rise_cyc - wr_cyc_q[2]))
         $display("FAIL wait_stall_cnt: grew by %0d expected %0d",
                  stall_cnt - stall0, done_rise_cyc - ((wr_cyc_q.size() == 3) ? wr_cyc_q[2] : 0));
      else n_pass++;
`endif
   endtask

   task automatic test_zero_cnt();
      agu_cmd_t c;
      int hs, acc;
      clear_logs();
      agu_force = 1'b1;
      c = rand_cmd(8'd0);
      offer_q = '{W'($urandom)};
      issue_cmd(c, hs);
      send_words(1'b0, 15, acc);
      wait_start(1, 40);
      repeat (2) @(negedge clk);
      n_checks++;
      if (sready_cyc != 0 || acc != 0 || wr_addr_q.size() != 0)
         $display("FAIL zero_no_load: s_ready cycles %0d accepted %0d writes %0d expected 0/0/0",
                  sready_cyc, acc, wr_addr_q.size());
      else n_pass++;
      n_checks++;
      if (sw_cyc_q.size() != 1 || st_cyc_q.size() != 1 || st_f_q[0] !== c)
         $display("FAIL zero_issue: %0d switches %0d starts fields %h expected 1/1 fields %h",
                  sw_cyc_q.size(), st_cyc_q.size(), (st_f_q.size() > 0) ? st_f_q[0] : '0, c);
      else n_pass++;
   endtask

   task automatic test_bubbles();
      agu_cmd_t c;
      int hs, acc;
      logic [31:0] lstall0;
      clear_logs();
      agu_force = 1'b1;
`ifdef PE_IDX_LOADER_STALL_CNT_EN
      lstall0 = load_stall_cnt;
`else
      lstall0 = '0;
`endif
      c = rand_cmd(8'd5);
      offer_q.delete();
      repeat (7) offer_q.push_back(W'($urandom));
      issue_cmd(c, hs);
      send_words(1'b1, 40, acc);
      wait_start(1, 40);
      @(negedge clk);
      n_checks++;
      if (acc != 5 || wr_addr_q.size() != 5)
         $display("FAIL bubble_count: accepted %0d writes %0d expected 5/5", acc, wr_addr_q.size());
      else n_pass++;
      for (int i = 0; i < wr_addr_q.size() && i < 5; i++) begin
         n_checks++;
         if (wr_addr_q[i] != i || wr_data_q[i] !== offer_q[i])
            $display("FAIL bubble_write%0d: addr %0d data %h expected addr %0d data %h",
                     i, wr_addr_q[i], wr_data_q[i], i, offer_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (s_ready !== 1'b0 || st_f_q.size() != 1 || st_f_q[0] !== c)
         $display("FAIL bubble_end: s_ready %b starts %0d expected s_ready 0 and one start with %h",
                  s_ready, st_f_q.size(), c);
      else n_pass++;
`ifdef PE_IDX_LOADER_STALL_CNT_EN
      n_checks++;
      if (load_stall_cnt - lstall0 != 32'(bubble_cyc))
         $display("FAIL bubble_load_stall_cnt: grew by %0d expected %0d",
                  load_stall_cnt - lstall0, bubble_cyc);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_mid();
      agu_cmd_t c;
      int hs, acc;
      clear_logs();
      agu_force = 1'b1;
      c = rand_cmd(8'd6);
      offer_q.delete();
      repeat (2) offer_q.push_back(W'($urandom));
      issue_cmd(c, hs);
      send_words(1'b0, 20, acc);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({cmd_ready, s_ready, idx_wr_en, switch_idx_buf, start, busy,
           idx_wr_addr, idx_wr_data, cur_f} !== '0)
         $display("FAIL midreset_outputs: ctrl %b addr %h data %h fields %h expected all zero",
                  {cmd_ready, s_ready, idx_wr_en, switch_idx_buf, start, busy},
                  idx_wr_addr, idx_wr_data, cur_f);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      n_checks++;
      if (acc != 2 || sw_cyc_q.size() != 0 || st_cyc_q.size() != 0)
         $display("FAIL midreset_abort: accepted %0d switches %0d starts %0d expected 2/0/0",
                  acc, sw_cyc_q.size(), st_cyc_q.size());
      else n_pass++;
      clear_logs();
      c = rand_cmd(8'd2);
      offer_q.delete();
      repeat (2) offer_q.push_back(W'($urandom));
      issue_cmd(c, hs);
      send_words(1'b0, 20, acc);
      wait_start(1, 30);
      n_checks++;
      if (wr_addr_q.size() != 2 || sw_cyc_q.size() != 1)
         $display("FAIL midreset_reload: writes %0d switches %0d expected 2/1",
                  wr_addr_q.size(), sw_cyc_q.size());
      else n_pass++;
      for (int i = 0; i < wr_addr_q.size() && i < 2; i++) begin
         n_checks++;
         if (wr_addr_q[i] != i || wr_data_q[i] !== offer_q[i])
            $display("FAIL midreset_write%0d: addr %0d data %h expected addr %0d data %h",
                     i, wr_addr_q[i], wr_data_q[i], i, offer_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      agu_cmd_t ca, cb;
      int hs, acc_a, acc_b, na, nb, rise_a;
      logic [W-1:0] exp_q[$];
      clear_logs();
      agu_auto = 1'b1;
      agu_left = 0;
      na = $urandom_range(1, 6);
      nb = $urandom_range(1, 6);
      ca = rand_cmd(8'(na));
      cb = rand_cmd(8'(nb));
      offer_q.delete();
      repeat (na) offer_q.push_back(W'($urandom));
      exp_q = offer_q;
      issue_cmd(ca, hs);
      send_words(1'b0, 40, acc_a);
      offer_q.delete();
      repeat (nb) offer_q.push_back(W'($urandom));
      exp_q = {exp_q, offer_q};
      issue_cmd(cb, hs);
      send_words(1'b0, 40, acc_b);
      wait_start(2, 200);
      rise_a = done_rise_cyc;
      @(negedge clk);
      n_checks++;
      if (wr_addr_q.size() != na + nb || acc_a != na || acc_b != nb)
         $display("FAIL b2b_count: writes %0d expected %0d", wr_addr_q.size(), na + nb);
      else n_pass++;
      for (int i = 0; i < wr_addr_q.size() && i < na + nb; i++) begin
         n_checks++;
         if (wr_addr_q[i] != ((i < na) ? i : i - na) || wr_data_q[i] !== exp_q[i])
            $display("FAIL b2b_write%0d: addr %0d data %h expected addr %0d data %h",
                     i, wr_addr_q[i], wr_data_q[i], (i < na) ? i : i - na, exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (st_cyc_q.size() != 2 || wr_cyc_q.size() != na + nb ||
          wr_cyc_q[na + nb - 1] >= rise_a || wr_cyc_q[na] <= st_cyc_q[0])
         $display("FAIL b2b_overlap: second load writes end at %0d, AGU done rose at %0d",
                  (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] : -1, rise_a);
      else n_pass++;
      n_checks++;
      if (sw_cyc_q.size() != 2 || st_cyc_q.size() != 2 ||
          rise_a <= st_cyc_q[0] + 1 || sw_cyc_q[1] != rise_a + 1 || st_cyc_q[1] != sw_cyc_q[1] + 1)
         $display("FAIL b2b_second_switch: switch at %0d start at %0d, AGU done returned at %0d",
                  (sw_cyc_q.size() > 1) ? sw_cyc_q[1] : -1,
                  (st_cyc_q.size() > 1) ? st_cyc_q[1] : -1, rise_a);
      else n_pass++;
      n_checks++;
      if (st_f_q.size() != 2 || st_f_q[0] !== ca || st_f_q[1] !== cb)
         $display("FAIL b2b_fields: got %h,%h expected %h,%h",
                  (st_f_q.size() > 0) ? st_f_q[0] : '0, (st_f_q.size() > 1) ? st_f_q[1] : '0, ca, cb);
      else n_pass++;
      agu_auto = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_agu_wait();
      test_zero_cnt();
      test_bubbles();
      test_reset_mid();
      test_back_to_back();
      n_checks++;
      if (field_glitch != 0)
         $display("FAIL field_stability: fields changed %0d times without start, expected 0", field_glitch);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
